// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART constants and helpers for the receive path.
// The receiver uses the same timing definitions.
package uart_rx_fifo_pkg;

    localparam int unsigned DATA_W        = 8;
    localparam int unsigned BITS_PER_CHAR = 10;
    localparam int unsigned DEF_FREQUENCY = 130;
    localparam int unsigned DEF_BAUDRATE  = 9600;
    localparam int unsigned TIMER_W       = 32;

    typedef logic [DATA_W-1:0] byte_t;

    // Clock cycles per bit period; frequency is given in MHz.
    function automatic int unsigned uart_period(input int unsigned freq_mhz,
                                                input int unsigned baud);
        return (freq_mhz * 1000000) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_idle_timer.sv
// Line-idle detector: pulses once when IDLE_CYC cycles pass after the last kick.
// Disarmed at reset and by clr, so it never fires before the first byte.
module uart_idle_timer
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned IDLE_CYC = 300
) (
    input  logic clk,
    input  logic rst,
    input  logic kick,
    input  logic clr,
    output logic idle_to
);

    localparam logic [TIMER_W-1:0] LAST_CNT = TIMER_W'(IDLE_CYC - 1);

    logic [TIMER_W-1:0] cnt;
    logic               armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            armed   <= 1'b0;
            idle_to <= 1'b0;
        end else begin
            idle_to <= 1'b0;
            if (kick) begin
                cnt   <= '0;
                armed <= 1'b1;
            end else if (clr) begin
                cnt   <= '0;
                armed <= 1'b0;
            end else if (armed) begin
                if (cnt == LAST_CNT) begin
                    cnt     <= '0;
                    armed   <= 1'b0;
                    idle_to <= 1'b1;
                end else begin
                    cnt <= cnt + TIMER_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: first-word-fall-through byte FIFO with level flags,
// synchronous flush and a line-idle timeout pulse for message framing.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned AFULL_LVL  = 12,
    parameter int unsigned FREQUENCY  = DEF_FREQUENCY,
    parameter int unsigned BAUDRATE   = DEF_BAUDRATE,
    parameter int unsigned IDLE_CHARS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     rx_data_i,
    input  logic                  rx_vld_i,
    output logic                  rx_rdy_o,
    input  logic                  flush_i,
    output logic [DATA_W-1:0]     dout_data_o,
    output logic                  dout_vld_o,
    input  logic                  dout_rdy_i,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  almost_full_o,
    output logic                  idle_to_o
);

    localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
    localparam int unsigned PW       = DEPTH_LOG2 + 1;
    localparam int unsigned IDLE_CYC = IDLE_CHARS * BITS_PER_CHAR
                                       * uart_period(FREQUENCY, BAUDRATE);

    byte_t         mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] level_q;
    logic          full_c;
    logic          empty_c;
    logic          wr_en;
    logic          rd_en;

    // Pointers carry a wrap bit so full and empty are distinguishable.
    assign full_c  = (wr_ptr[PW-1] != rd_ptr[PW-1])
                  && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    assign empty_c = (wr_ptr == rd_ptr);

    assign rx_rdy_o      = !full_c && !flush_i;
    assign wr_en         = rx_vld_i && rx_rdy_o;
    assign dout_vld_o    = !empty_c;
    assign rd_en         = dout_vld_o && dout_rdy_i && !flush_i;
    assign dout_data_o   = empty_c ? '0 : mem[rd_ptr[PW-2:0]];
    assign level_o       = level_q;
    assign empty_o       = empty_c;
    assign full_o        = full_c;
    assign almost_full_o = (level_q >= PW'(AFULL_LVL));

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[PW-2:0]] <= rx_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   level_q <= level_q + PW'(1);
                2'b01:   level_q <= level_q - PW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    uart_idle_timer #(
        .IDLE_CYC (IDLE_CYC)
    ) u_idle_timer (
        .clk     (clk),
        .rst     (rst),
        .kick    (wr_en),
        .clr     (flush_i),
        .idle_to (idle_to_o)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a byte-queue scoreboard predicts data order,
// level and flags; idle timing is checked against fixed cycle counts.
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data_i;
    logic       rx_vld_i;
    logic       rx_rdy_o;
    logic       flush_i;
    logic [7:0] dout_data_o;
    logic       dout_vld_o;
    logic       dout_rdy_i;
    logic [4:0] level_o;
    logic       empty_o;
    logic       full_o;
    logic       almost_full_o;
    logic       idle_to_o;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    uart_rx_fifo #(
        .DEPTH_LOG2 (4),
        .AFULL_LVL  (12),
        .FREQUENCY  (1),
        .BAUDRATE   (100000),
        .IDLE_CHARS (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data_i     (rx_data_i),
        .rx_vld_i      (rx_vld_i),
        .rx_rdy_o      (rx_rdy_o),
        .flush_i       (flush_i),
        .dout_data_o   (dout_data_o),
        .dout_vld_o    (dout_vld_o),
        .dout_rdy_i    (dout_rdy_i),
        .level_o       (level_o),
        .empty_o       (empty_o),
        .full_o        (full_o),
        .almost_full_o (almost_full_o),
        .idle_to_o     (idle_to_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock of stimulus; the scoreboard decides acceptance from its own occupancy.
    task automatic cycle(input bit wr, input logic [7:0] d, input bit rd, input bit fl);
        bit         wr_acc;
        bit         rd_acc;
        logic [7:0] e;
        rx_vld_i   = wr;
        rx_data_i  = d;
        dout_rdy_i = rd;
        flush_i    = fl;
        #1;
        chk("rx_rdy", 32'(rx_rdy_o), 32'(exp_q.size() < 16 && !fl));
        chk("dout_vld", 32'(dout_vld_o), 32'(exp_q.size() != 0));
        wr_acc = wr && (exp_q.size() < 16) && !fl;
        rd_acc = rd && (exp_q.size() != 0) && !fl;
        if (rd_acc) begin
            e = exp_q.pop_front();
            chk("dout_data", 32'(dout_data_o), 32'(e));
        end
        if (fl) exp_q.delete();
        if (wr_acc) exp_q.push_back(d);
        tick();
        rx_vld_i   = 1'b0;
        dout_rdy_i = 1'b0;
        flush_i    = 1'b0;
        chk("level", 32'(level_o), 32'(exp_q.size()));
        chk("empty", 32'(empty_o), 32'(exp_q.size() == 0));
        chk("full", 32'(full_o), 32'(exp_q.size() == 16));
        chk("afull", 32'(almost_full_o), 32'(exp_q.size() >= 12));
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rx_rdy"}, 32'(rx_rdy_o), 32'd1);
        chk({tag, "_dout_vld"}, 32'(dout_vld_o), 32'd0);
        chk({tag, "_dout_data"}, 32'(dout_data_o), 32'h00);
        chk({tag, "_level"}, 32'(level_o), 32'd0);
        chk({tag, "_empty"}, 32'(empty_o), 32'd1);
        chk({tag, "_full"}, 32'(full_o), 32'd0);
        chk({tag, "_afull"}, 32'(almost_full_o), 32'd0);
        chk({tag, "_idle"}, 32'(idle_to_o), 32'd0);
    endtask

    // Counts cycles after a write edge; records first pulse position and pulse count.
    task automatic watch_idle(input int ncyc, output int first, output int pulses);
        first  = -1;
        pulses = 0;
        for (int n = 1; n <= ncyc; n++) begin
            tick();
            if (idle_to_o === 1'b1) begin
                pulses++;
                if (first < 0) first = n;
            end
        end
    endtask

    initial begin
        int first;
        int pulses;
        rst        = 1'b1;
        rx_vld_i   = 1'b0;
        rx_data_i  = 8'h00;
        dout_rdy_i = 1'b0;
        flush_i    = 1'b0;
        tick();
        chk_reset_outputs("por");
        rst = 1'b0;
        tick();

        // Reset mid-stream at level 5, asserted between clock edges
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
        chk("pre_rst_level", 32'(level_o), 32'd5);
        #3;
        rst = 1'b1;
        #1;
        chk_reset_outputs("async");
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();

        // Single byte with consumer stalled: visible one cycle after the write
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("a5_vld", 32'(dout_vld_o), 32'd1);
        chk("a5_data", 32'(dout_data_o), 32'hA5);
        drain();
        chk("empty_data", 32'(dout_data_o), 32'h00);

        // Fill to full, 17th byte held back until one slot is freed
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        rx_vld_i  = 1'b1;
        rx_data_i = 8'h10;
        #1;
        chk("full_blocks", 32'(rx_rdy_o), 32'd0);
        cycle(1'b1, 8'h10, 1'b1, 1'b0);
        chk("rdy_after_read", 32'(rx_rdy_o), 32'd1);
        cycle(1'b1, 8'h10, 1'b0, 1'b0);
        chk("refull", 32'(full_o), 32'd1);
        drain();

        // Streaming at level 3 across pointer wrap
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
        chk("stream_level", 32'(level_o), 32'd3);
        drain();

        // Flush at level 7 with concurrent read and write
        for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'h77, 1'b1, 1'b1);
        chk("flush_level", 32'(level_o), 32'd0);
        chk("flush_empty", 32'(empty_o), 32'd1);
        watch_idle(400, first, pulses);
        chk("flush_no_idle", 32'(pulses), 32'd0);

        // Idle timeout exactly 300 cycles after a lone write, once only
        cycle(1'b1, 8'h66, 1'b0, 1'b0);
        watch_idle(450, first, pulses);
        chk("idle_at", 32'(first), 32'd300);
        chk("idle_once", 32'(pulses), 32'd1);

        // Second byte at cycle 150 restarts the count
        cycle(1'b1, 8'h67, 1'b0, 1'b0);
        watch_idle(149, first, pulses);
        chk("idle_early", 32'(pulses), 32'd0);
        cycle(1'b1, 8'h68, 1'b0, 1'b0);
        watch_idle(450, first, pulses);
        chk("idle_restart_at", 32'(first), 32'd300);
        chk("idle_restart_once", 32'(pulses), 32'd1);
        drain();
        chk("final_empty", 32'(empty_o), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
